// File: rtl/cell_char_pkg.sv
// Shared types and constants for the standard-cell characterization sequencer.
package cell_char_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  // P1N2SER, vector index {A,B,C}: Z=1 when !A && !(B&C), Z=0 when A&B&C, rest masked.
  localparam logic [7:0] P1N2SER_EXP_VAL  = 8'b0000_0111;
  localparam logic [7:0] P1N2SER_EXP_MASK = 8'b1000_0111;

  // Bits needed to hold SETTLE_CYC-1.
  function automatic int unsigned cnt_width(input int unsigned settle_cyc);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < settle_cyc) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/cell_char_seq_z_sync2.sv
// Two-flop synchronizer for the asynchronous cell-under-test output.
module z_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cell_char_seq.sv
// Exhaustive self-test sequencer: steps the CUT through every input vector,
// samples the synchronized output and scores it against a masked truth table.
module cell_char_seq
  import cell_char_pkg::*;
#(
  parameter int unsigned        N_IN       = 3,
  parameter int unsigned        SETTLE_CYC = 4,
  parameter logic [2**N_IN-1:0] EXP_VAL    = P1N2SER_EXP_VAL,
  parameter logic [2**N_IN-1:0] EXP_MASK   = P1N2SER_EXP_MASK
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            START,
  input  logic            ABORT,
  input  logic            Z_IN,
  output logic [N_IN-1:0] DRV,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [N_IN:0]   FAIL_CNT,
  output logic [N_IN-1:0] FIRST_FAIL,
  output logic            FIRST_FAIL_VLD
);

  localparam int unsigned     CW     = cnt_width(SETTLE_CYC);
  localparam logic [CW-1:0]   RELOAD = CW'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] LAST   = '1;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [N_IN-1:0] drv_nxt, ff_nxt;
  logic [N_IN:0]   fail_nxt;
  logic            busy_nxt, done_nxt, pass_nxt, vld_nxt;
  logic            to_finish;
  logic            z_s;

  z_sync2 u_sync (
    .clk (CK),
    .rst (RST),
    .d   (Z_IN),
    .q   (z_s)
  );

  // DRV doubles as the vector index; it is only meaningful while BUSY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    drv_nxt   = DRV;
    busy_nxt  = BUSY;
    done_nxt  = 1'b0;
    pass_nxt  = PASS;
    fail_nxt  = FAIL_CNT;
    ff_nxt    = FIRST_FAIL;
    vld_nxt   = FIRST_FAIL_VLD;
    to_finish = 1'b0;

    case (state)
      IDLE: begin
        if (START && !ABORT) begin
          state_nxt = SETTLE;
          drv_nxt   = '0;
          cnt_nxt   = RELOAD;
          fail_nxt  = '0;
          vld_nxt   = 1'b0;
          pass_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      SETTLE: begin
        cnt_nxt = cnt - 1'b1;
        if (ABORT)                to_finish = 1'b1;
        else if (cnt_nxt == '0)   state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (EXP_MASK[DRV] && (z_s != EXP_VAL[DRV])) begin
          fail_nxt = FAIL_CNT + 1'b1;
          if (!FIRST_FAIL_VLD) begin
            ff_nxt  = DRV;
            vld_nxt = 1'b1;
          end
        end
        if (ABORT || (DRV == LAST)) begin
          to_finish = 1'b1;
        end else begin
          drv_nxt   = DRV + 1'b1;
          cnt_nxt   = RELOAD;
          state_nxt = SETTLE;
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // PASS uses fail_nxt so a mismatch in the final SAMPLE is already counted.
    if (to_finish) begin
      state_nxt = FINISH;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b1;
      drv_nxt   = '0;
      pass_nxt  = !ABORT && (fail_nxt == '0);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state          <= IDLE;
      cnt            <= '0;
      DRV            <= '0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      PASS           <= 1'b0;
      FAIL_CNT       <= '0;
      FIRST_FAIL     <= '0;
      FIRST_FAIL_VLD <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      DRV            <= drv_nxt;
      BUSY           <= busy_nxt;
      DONE           <= done_nxt;
      PASS           <= pass_nxt;
      FAIL_CNT       <= fail_nxt;
      FIRST_FAIL     <= ff_nxt;
      FIRST_FAIL_VLD <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_cell_char_seq.sv
// Self-checking bench for cell_char_seq: behavioural cell model on Z_IN,
// directed vector table, randomized truth tables and multi-cycle corner cases.
module tb_cell_char_seq;

  localparam int M_GOOD = 0;
  localparam int M_S0   = 1;
  localparam int M_S1   = 2;
  localparam int M_TAB  = 3;

  localparam logic [7:0] EXPV = 8'b0000_0111;
  localparam logic [7:0] EXPM = 8'b1000_0111;

  logic       ck = 1'b0;
  logic       rst, start, abort, z_in;
  logic [2:0] drv, first_fail;
  logic       busy, done, pass, first_vld;
  logic [3:0] fail_cnt;

  logic       start3, abort3, z3;
  logic [2:0] drv3, ff3;
  logic       busy3, done3, pass3, vld3;
  logic [3:0] fcnt3;

  int         zmode;
  logic [7:0] ztab;
  int         tests  = 0;
  int         failed = 0;

  always #5 ck = ~ck;

  cell_char_seq dut (
    .CK(ck), .RST(rst), .START(start), .ABORT(abort), .Z_IN(z_in),
    .DRV(drv), .BUSY(busy), .DONE(done), .PASS(pass), .FAIL_CNT(fail_cnt),
    .FIRST_FAIL(first_fail), .FIRST_FAIL_VLD(first_vld)
  );

  cell_char_seq #(.SETTLE_CYC(3)) dut3 (
    .CK(ck), .RST(rst), .START(start3), .ABORT(abort3), .Z_IN(z3),
    .DRV(drv3), .BUSY(busy3), .DONE(done3), .PASS(pass3), .FAIL_CNT(fcnt3),
    .FIRST_FAIL(ff3), .FIRST_FAIL_VLD(vld3)
  );

  function automatic logic good_z(input logic [2:0] v);
    logic a, b, c;
    {a, b, c} = v;
    if (!a && !(b && c)) return 1'b1;
    if (a && b && c)     return 1'b0;
    return 1'bx;
  endfunction

  always_comb begin
    z_in = 1'b0;
    case (zmode)
      M_GOOD:  z_in = good_z(drv);
      M_S0:    z_in = 1'b0;
      M_S1:    z_in = 1'b1;
      default: z_in = ztab[drv];
    endcase
  end

  always_comb z3 = good_z(drv3);

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Abort raised during cycle n (vector (n-1)/4) stops the run; a SAMPLE cycle
  // (n multiple of 4) still scores its own vector.
  function automatic void model(input logic [7:0] zt, input int ab,
                                output logic p, output int c, output int f,
                                output logic v, output int dc);
    int ncmp;
    ncmp = (ab == 0) ? 8 : ((ab % 4 == 0) ? ab / 4 : (ab - 1) / 4);
    c = 0; f = 0; v = 1'b0;
    for (int i = 0; i < ncmp; i++) begin
      if (EXPM[i] && (zt[i] != EXPV[i])) begin
        if (!v) begin f = i; v = 1'b1; end
        c++;
      end
    end
    p  = (ab == 0) && (c == 0);
    dc = (ab == 0) ? 33 : ab + 1;
  endfunction

  task automatic run(input int mode, input logic [7:0] zt, input int abort_cyc,
                     input int start_cyc, output int done_cyc, output logic seq_ok,
                     output logic r_pass, output int r_cnt, output int r_ff,
                     output logic r_vld);
    zmode = mode;
    ztab  = zt;
    @(negedge ck); start = 1'b1;
    @(negedge ck); start = 1'b0;
    done_cyc = 0;
    seq_ok   = 1'b1;
    r_pass = 1'b0; r_cnt = 0; r_ff = 0; r_vld = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (done) begin
        done_cyc = n;
        r_pass = pass; r_cnt = int'(fail_cnt); r_ff = int'(first_fail); r_vld = first_vld;
        if (drv != 3'd0 || busy) seq_ok = 1'b0;
        break;
      end
      if (!busy || drv != 3'((n - 1) / 4)) seq_ok = 1'b0;
      abort = (n == abort_cyc);
      start = (n == start_cyc);
      @(negedge ck);
    end
    abort = 1'b0;
    start = 1'b0;
    @(negedge ck);
    if (done || busy) seq_ok = 1'b0;
  endtask

  typedef struct {
    string name;
    int    mode;
    int    abort_cyc;
    int    start_cyc;
    logic  exp_pass;
    int    exp_cnt;
    int    exp_ff;
    logic  exp_vld;
    int    exp_done;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int         dc, cnt, ff, e_cnt, e_ff, e_dc, ab, n3;
    logic       ok, p, v, e_p, e_v, found, saw_done;
    logic [7:0] zt;

    tbl[0] = '{"good",         M_GOOD, 0,  0,  1'b1, 0, 0, 1'b0, 33};
    tbl[1] = '{"stuck0",       M_S0,   0,  0,  1'b0, 3, 0, 1'b1, 33};
    tbl[2] = '{"stuck1",       M_S1,   0,  0,  1'b0, 1, 7, 1'b1, 33};
    tbl[3] = '{"s0_abort_v3",  M_S0,   13, 0,  1'b0, 3, 0, 1'b1, 14};
    tbl[4] = '{"good_rerun",   M_GOOD, 0,  0,  1'b1, 0, 0, 1'b0, 33};
    tbl[5] = '{"good_abort",   M_GOOD, 13, 0,  1'b0, 0, 0, 1'b0, 14};
    tbl[6] = '{"start_busy",   M_GOOD, 0,  10, 1'b1, 0, 0, 1'b0, 33};
    tbl[7] = '{"s1_abort_smp", M_S1,   32, 0,  1'b0, 1, 7, 1'b1, 33};
    tbl[8] = '{"s0_abort_smp0",M_S0,   4,  0,  1'b0, 1, 0, 1'b1, 5};

    zmode = M_GOOD; ztab = '0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    repeat (3) @(negedge ck);
    check("rst_drv",  int'(drv), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_fcnt", int'(fail_cnt), 0);
    check("rst_ff",   int'(first_fail), 0);
    check("rst_vld",  int'(first_vld), 0);
    rst = 1'b0;

    // START together with ABORT in IDLE must not launch a run.
    @(negedge ck); start = 1'b1; abort = 1'b1;
    @(negedge ck); start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", int'(busy), 0);
    @(negedge ck);
    check("start_abort_idle_done", int'(done), 0);

    foreach (tbl[i]) begin
      run(tbl[i].mode, 8'h00, tbl[i].abort_cyc, tbl[i].start_cyc, dc, ok, p, cnt, ff, v);
      check({tbl[i].name, "_done_cyc"}, dc, tbl[i].exp_done);
      check({tbl[i].name, "_seq"}, int'(ok), 1);
      check({tbl[i].name, "_pass"}, int'(p), int'(tbl[i].exp_pass));
      check({tbl[i].name, "_fcnt"}, cnt, tbl[i].exp_cnt);
      check({tbl[i].name, "_vld"}, int'(v), int'(tbl[i].exp_vld));
      if (tbl[i].exp_vld) check({tbl[i].name, "_ff"}, ff, tbl[i].exp_ff);
    end

    for (int r = 0; r < 24; r++) begin
      zt = 8'($urandom);
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 32)) : 0;
      model(zt, ab, e_p, e_cnt, e_ff, e_v, e_dc);
      run(M_TAB, zt, ab, int'($urandom_range(0, 40)), dc, ok, p, cnt, ff, v);
      check($sformatf("rnd%0d_done_cyc", r), dc, e_dc);
      check($sformatf("rnd%0d_seq", r), int'(ok), 1);
      check($sformatf("rnd%0d_pass", r), int'(p), int'(e_p));
      check($sformatf("rnd%0d_fcnt", r), cnt, e_cnt);
      check($sformatf("rnd%0d_vld", r), int'(v), int'(e_v));
      if (e_v) check($sformatf("rnd%0d_ff", r), ff, e_ff);
    end

    // Reset mid-run at vector 5 with a partial failure count already latched.
    zmode = M_S0;
    @(negedge ck); start = 1'b1;
    @(negedge ck); start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (drv == 3'd5) begin found = 1'b1; break; end
      @(negedge ck);
    end
    check("rst_mid_reached_v5", int'(found), 1);
    check("rst_mid_pre_fcnt", int'(fail_cnt), 3);
    rst = 1'b1;
    @(negedge ck);
    check("rst_mid_drv",  int'(drv), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    check("rst_mid_pass", int'(pass), 0);
    check("rst_mid_fcnt", int'(fail_cnt), 0);
    check("rst_mid_ff",   int'(first_fail), 0);
    check("rst_mid_vld",  int'(first_vld), 0);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge ck);
      if (done || busy) saw_done = 1'b1;
    end
    check("rst_mid_no_done", int'(saw_done), 0);

    // Shortest legal settle time.
    @(negedge ck); start3 = 1'b1;
    @(negedge ck); start3 = 1'b0;
    n3 = 0;
    for (int n = 1; n <= 100; n++) begin
      if (done3) begin n3 = n; break; end
      @(negedge ck);
    end
    check("settle3_done_cyc", n3, 25);
    check("settle3_pass", int'(pass3), 1);
    check("settle3_fcnt", int'(fcnt3), 0);
    check("settle3_vld", int'(vld3), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cell_char_seq.md
# cell_char_seq

Self-test sequencer for a single complex-gate standard cell instantiated as an on-die characterization structure. It drives the cell's inputs exhaustively through all 2^N_IN vectors, waits a programmable settle time per vector, samples the cell output through a two-flop synchronizer and compares the sample against a masked expected truth table. It reports pass/fail, the mismatch count and the first failing vector. It sits between the test-control register block and the analog cell-under-test (CUT).

## Interface

**Parameters**
- N_IN, 3: number of CUT inputs. Legal range 1..4.
- SETTLE_CYC, 4: cycles from a DRV change to the sample edge. Minimum 3, which covers the synchronizer latency.
- EXP_VAL, 8'b0000_0111: expected Z per vector index. Bit i is the expected value for vector i.
- EXP_MASK, 8'b1000_0111: compare enable per vector index. 0 means don't-care, used for floating-output or contention vectors.

**Ports**
- CK, in, 1: clock.
- RST, in, 1: synchronous, active-high reset.
- START, in, 1: one-cycle request to begin a run. Ignored unless the block is IDLE.
- ABORT, in, 1: terminate the current run.
- Z_IN, in, 1: CUT output. Asynchronous to CK.
- DRV, out, N_IN: CUT inputs. DRV[N_IN-1] is the MSB of the vector index; for N_IN=3 the order is {A,B,C}.
- BUSY, out, 1: a run is in progress.
- DONE, out, 1: one-cycle pulse at the end of a run, whether completed or aborted.
- PASS, out, 1: the last run completed with zero mismatches.
- FAIL_CNT, out, N_IN+1: mismatch count for the last run.
- FIRST_FAIL, out, N_IN: vector index of the first mismatch.
- FIRST_FAIL_VLD, out, 1: FIRST_FAIL holds a valid index.

## Operation

**States:** IDLE, SETTLE, SAMPLE, FINISH.

**Reset**
- State goes to IDLE.
- DRV=0, BUSY=0, DONE=0, PASS=0, FAIL_CNT=0, FIRST_FAIL=0, FIRST_FAIL_VLD=0.
- Both synchronizer flops are cleared to 0.

**Transitions**
- IDLE→SETTLE on START.
  - Vector index cleared to 0 and DRV=0.
  - Settle counter loaded with SETTLE_CYC-1.
  - FAIL_CNT, FIRST_FAIL_VLD and PASS cleared.
  - BUSY=1.
- SETTLE: the counter decrements each cycle. At 0 the state moves to SAMPLE.
- SAMPLE: compare the synchronized Z against EXP_VAL[idx], only where EXP_MASK[idx]=1.
  - On a mismatch: FAIL_CNT increments. If FIRST_FAIL_VLD=0, capture FIRST_FAIL=idx and set FIRST_FAIL_VLD=1.
  - If idx is not the last vector: idx+1, DRV=idx+1, counter reloaded, back to SETTLE.
  - If idx = 2^N_IN-1: go to FINISH.
- FINISH:
  - DONE=1 for one cycle.
  - BUSY=0.
  - PASS = (FAIL_CNT==0, including a mismatch in the final SAMPLE).
  - DRV returns to 0.
  - Next state is IDLE.

**Abort**
- ABORT in SETTLE or SAMPLE goes to FINISH next cycle.
- A SAMPLE that coincides with ABORT still performs its compare.
- PASS is forced to 0. FAIL_CNT and FIRST_FAIL keep their partial values.
- ABORT in IDLE has no effect.
- ABORT has priority over START.

**Boundaries**
- FAIL_CNT width N_IN+1 cannot overflow, because the count is at most 2^N_IN.
- START while BUSY is ignored. It is not queued.
- RST mid-run returns the block to IDLE on the next edge with no DONE pulse.
- Results hold until the next START or RST.

## Timing

- DRV is registered and changes only on the edge that enters SETTLE.
- For each vector:
  - SETTLE lasts SETTLE_CYC-1 cycles, then SAMPLE lasts 1 cycle.
  - Vector dwell is exactly SETTLE_CYC cycles.
  - The sample is the synchronizer output at the SAMPLE cycle, i.e. Z_IN as captured SETTLE_CYC-2 cycles after DRV changed.
- Full run:
  - START registered at edge t gives BUSY=1 from t+1.
  - DONE is asserted in the cycle after edge t + 2^N_IN·SETTLE_CYC.
  - With defaults this is 32 cycles of BUSY, then the DONE cycle.
- Abort latency is 1 cycle from ABORT to DONE.

## Structure

- Package cell_char_pkg holds:
  - The state enum.
  - Default EXP_VAL/EXP_MASK constants for the P1N2SER cell function: Z=1 when A=0 and not (B&C); Z=0 when A&B&C; all other vectors masked.
  - A function computing the counter width from SETTLE_CYC.
- One sub-module, z_sync2: a two-flop synchronizer with synchronous reset, used on Z_IN.
- Everything else is flat in cell_char_seq.

## Test plan

- **Good cell, defaults:** behavioural P1N2SER model driving Z_IN, with X on masked vectors. START → DONE at cycle 33, PASS=1, FAIL_CNT=0, FIRST_FAIL_VLD=0; DRV steps 0..7 every 4 cycles.
- **Stuck-at-0 Z_IN:** mismatches on vectors 0,1,2 → PASS=0, FAIL_CNT=3, FIRST_FAIL=0, FIRST_FAIL_VLD=1.
- **Stuck-at-1 Z_IN:** only vector 7 checked low → FAIL_CNT=1, FIRST_FAIL=7; PASS=0 on the DONE cycle.
- **ABORT during vector 3 SETTLE:** DONE the next cycle, PASS=0, DRV=0, FAIL_CNT reflects vectors 0–2 only. A START re-issued afterwards completes a clean run.
- **START pulsed while BUSY, and START with ABORT in IDLE:** the run is unaffected, with DONE still at cycle 33. Simultaneous START+ABORT in IDLE leaves BUSY=0.
- **RST asserted while DRV=5:** next cycle all outputs are at reset values and no DONE pulse occurs. SETTLE_CYC=3 variant: full run DONE at cycle 25.
